// File: rtl/svo_term_arb.sv
// rtl/svo_term_arb.sv - message-granular round-robin arbiter feeding the svo_term byte input
// Optional stall timeout: define SVO_TERM_ARB_TIMEOUT_EN.
module svo_term_arb #(
  parameter int NUM_REQ        = 2,
  parameter int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   s_tvalid,
  output logic [NUM_REQ-1:0]   s_tready,
  input  logic [8*NUM_REQ-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]   s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [7:0]           m_tdata,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 abort
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("svo_term_arb: parameter out of range");
  end

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] next_grant;
  logic [GW-1:0] idx;
  logic          req_any;
  logic          out_free;
  logic          accept;
  logic          timeout_hit;
  logic [7:0]    g_byte;

  assign req_any  = |s_tvalid;
  assign out_free = !m_tvalid || m_tready;
  assign accept   = (state == XFER) && s_tvalid[grant_id] && out_free;
  assign g_byte   = s_tdata[{grant_id, 3'b000} +: 8];

  // Walk from farthest to nearest so the nearest valid index after grant_id wins.
  always_comb begin
    next_grant = grant_id;
    idx        = grant_id;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(grant_id) + k) % NUM_REQ);
      if (s_tvalid[idx]) next_grant = idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_tready  = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) state_nxt = XFER;
      end
      XFER: begin
        busy = 1'b1;
        if (out_free) s_tready[grant_id] = 1'b1;
        if (accept && s_tlast[grant_id]) state_nxt = IDLE;
        else if (timeout_hit)            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-entry output register; grant_id doubles as the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= 8'h00;
      grant_id <= GW'(NUM_REQ - 1);
    end else begin
      if (state == IDLE && req_any) grant_id <= next_grant;
      if (accept) begin
        m_tdata  <= g_byte;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

`ifdef SVO_TERM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          abort_q;

  assign timeout_hit = (state == XFER) && !s_tvalid[grant_id] &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign abort = abort_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= timeout_hit;
      if (state != XFER || accept || timeout_hit) to_cnt <= '0;
      else if (!s_tvalid[grant_id])               to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign abort       = 1'b0;
`endif

endmodule
